// File: rtl/c_vc_credit_sched.sv
// Credit-based round-robin scheduler sharing one link among num_vcs VCs; packet-locked grants.
// Latency: gnt is combinational from req (0 cycles); credits visible next cycle (same cycle with C_VC_CREDIT_SCHED_BYPASS_EN).
// Backpressure: a VC with no downstream credits is ineligible; a locked VC at 0 credits idles the link.
module c_vc_credit_sched #(
    parameter int num_vcs = 4,
    parameter int depth = 8,
    localparam int vc_idx_width = $clog2(num_vcs),
    localparam int free_width = $clog2(depth + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    active,
    input  logic [num_vcs-1:0]      req,
    input  logic [num_vcs-1:0]      req_tail,
    output logic [num_vcs-1:0]      gnt,
    output logic                    gnt_vld,
    input  logic                    cred_vld,
    input  logic [vc_idx_width-1:0] cred_vc,
    output logic [num_vcs-1:0]      vc_empty,
    output logic [num_vcs-1:0]      vc_full,
    output logic [1:0]              errors
);

    localparam int cw = vc_idx_width + 1;
    localparam logic [free_width-1:0] full_cnt = free_width'(depth);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                  state;
    logic [vc_idx_width-1:0] rr_ptr;
    logic [vc_idx_width-1:0] lock_vc;
    logic [vc_idx_width-1:0] pick;
    logic [vc_idx_width-1:0] gnt_vc;
    logic [cw-1:0]           cand;
    logic [free_width-1:0]   free     [num_vcs];
    logic [free_width-1:0]   free_nxt [num_vcs];
    logic [num_vcs-1:0]      elig;
    logic [num_vcs-1:0]      cred_hit;
    logic                    found;
    logic                    gnt_any;
    logic                    legal;
    logic                    ovf;

    // With a power-of-two VC count every index is legal.
    if ((1 << vc_idx_width) == num_vcs) begin : g_pow2
        assign legal = 1'b1;
    end else begin : g_npow2
        assign legal = {1'b0, cred_vc} < cw'(num_vcs);
    end

    always_comb begin
        ovf = 1'b0;
        for (int v = 0; v < num_vcs; v++) begin
            cred_hit[v] = cred_vld & legal & (cred_vc == vc_idx_width'(v));
`ifdef C_VC_CREDIT_SCHED_BYPASS_EN
            elig[v] = req[v] & ((free[v] != '0) | cred_hit[v]);
`else
            elig[v] = req[v] & (free[v] != '0);
`endif
            ovf = ovf | (cred_hit[v] & (free[v] == full_cnt));
        end
        errors = {cred_vld & ~legal, ovf};
    end

    // First eligible VC at or after rr_ptr, in cyclic order.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < num_vcs; i++) begin
            cand = {1'b0, rr_ptr} + cw'(i);
            if (cand >= cw'(num_vcs)) begin
                cand = cand - cw'(num_vcs);
            end
            if (!found && elig[cand[vc_idx_width-1:0]]) begin
                found = 1'b1;
                pick  = cand[vc_idx_width-1:0];
            end
        end
    end

    always_comb begin
        gnt_vc  = (state == LOCKED) ? lock_vc : pick;
        gnt_any = active & reset & ((state == LOCKED) ? elig[lock_vc] : found);
        gnt_vld = gnt_any;
        for (int v = 0; v < num_vcs; v++) begin
            gnt[v] = gnt_any & (gnt_vc == vc_idx_width'(v));
        end
    end

    // A return into a full counter saturates rather than wrapping.
    always_comb begin
        for (int v = 0; v < num_vcs; v++) begin
            case ({gnt[v], cred_hit[v]})
                2'b10:   free_nxt[v] = free[v] - 1'b1;
                2'b01:   free_nxt[v] = (free[v] == full_cnt) ? free[v] : free[v] + 1'b1;
                default: free_nxt[v] = free[v];
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < num_vcs; v++) begin
                free[v] <= full_cnt;
            end
            vc_empty <= '1;
            vc_full  <= '0;
        end else if (active) begin
            for (int v = 0; v < num_vcs; v++) begin
                free[v]     <= free_nxt[v];
                vc_empty[v] <= (free_nxt[v] == full_cnt);
                vc_full[v]  <= (free_nxt[v] == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            lock_vc <= '0;
        end else if (gnt_any) begin
            if (req_tail[gnt_vc]) begin
                state  <= IDLE;
                rr_ptr <= (gnt_vc == vc_idx_width'(num_vcs - 1)) ? '0 : gnt_vc + 1'b1;
            end else begin
                state   <= LOCKED;
                lock_vc <= gnt_vc;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset && active && errors[0]) begin
            $display("c_vc_credit_sched: credit overflow on vc %0d", cred_vc);
        end
        if (reset && active && errors[1]) begin
            $display("c_vc_credit_sched: illegal credit vc index %0d dropped", cred_vc);
        end
    end
`endif

endmodule

// File: tb/tb_c_vc_credit_sched.sv
// Bench for c_vc_credit_sched: directed scenarios plus randomized traffic against a queue-free arithmetic model.
module tb_c_vc_credit_sched;

    localparam int NV  = 4;
    localparam int DEP = 8;
`ifdef C_VC_CREDIT_SCHED_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, active, cred_vld, gnt_vld;
    logic [3:0] req, req_tail, gnt, vc_empty, vc_full;
    logic [1:0] cred_vc, errors;

    logic       s_active, s_cred_vld, s_gnt_vld;
    logic [2:0] s_req, s_tail, s_gnt, s_empty, s_full;
    logic [1:0] s_cred_vc, s_errors;

    c_vc_credit_sched #(.num_vcs(4), .depth(8)) dut (
        .clk(clk), .reset(reset), .active(active), .req(req), .req_tail(req_tail),
        .gnt(gnt), .gnt_vld(gnt_vld), .cred_vld(cred_vld), .cred_vc(cred_vc),
        .vc_empty(vc_empty), .vc_full(vc_full), .errors(errors)
    );

    c_vc_credit_sched #(.num_vcs(3), .depth(1)) dut_small (
        .clk(clk), .reset(reset), .active(s_active), .req(s_req), .req_tail(s_tail),
        .gnt(s_gnt), .gnt_vld(s_gnt_vld), .cred_vld(s_cred_vld), .cred_vc(s_cred_vc),
        .vc_empty(s_empty), .vc_full(s_full), .errors(s_errors)
    );

    int mfree [NV];
    bit mlocked;
    int mlock_vc;
    int mrr;
    logic [3:0] exp_gnt, exp_empty, exp_full;
    logic [1:0] exp_err;
    int total = 0;
    int bad = 0;

    task automatic model_reset();
        for (int v = 0; v < NV; v++) mfree[v] = DEP;
        mlocked = 1'b0;
        mlock_vc = 0;
        mrr = 0;
    endtask

    task automatic model_eval();
        bit elig [NV];
        bit done;
        int g;
        done = 1'b0;
        exp_gnt = '0;
        for (int v = 0; v < NV; v++) begin
            exp_empty[v] = (mfree[v] == DEP);
            exp_full[v]  = (mfree[v] == 0);
            elig[v] = req[v] && (mfree[v] > 0 || (BYP && cred_vld && int'(cred_vc) == v));
        end
        if (active && reset) begin
            if (mlocked) begin
                if (elig[mlock_vc]) exp_gnt[mlock_vc] = 1'b1;
            end else begin
                for (int i = 0; i < NV; i++) begin
                    g = (mrr + i) % NV;
                    if (!done && elig[g]) begin
                        exp_gnt[g] = 1'b1;
                        done = 1'b1;
                    end
                end
            end
        end
        exp_err[0] = cred_vld && (mfree[cred_vc] == DEP);
        exp_err[1] = 1'b0;
    endtask

    task automatic model_step();
        int g;
        int net;
        g = -1;
        if (active && reset) begin
            for (int v = 0; v < NV; v++) if (exp_gnt[v]) g = v;
            for (int v = 0; v < NV; v++) begin
                net = mfree[v] - ((g == v) ? 1 : 0) + ((cred_vld && int'(cred_vc) == v) ? 1 : 0);
                mfree[v] = (net > DEP) ? DEP : net;
            end
            if (g >= 0) begin
                if (req_tail[g]) begin
                    mlocked = 1'b0;
                    mrr = (g + 1) % NV;
                end else begin
                    mlocked = 1'b1;
                    mlock_vc = g;
                end
            end
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] t, input logic cv,
                         input logic [1:0] cvc, input logic act);
        @(negedge clk);
        req = r; req_tail = t; cred_vld = cv; cred_vc = cvc; active = act;
        #1;
        model_eval();
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
    endtask

    task automatic zero_inputs();
        req = '0; req_tail = '0; cred_vld = 1'b0; cred_vc = '0; active = 1'b0;
        s_req = '0; s_tail = '0; s_cred_vld = 1'b0; s_cred_vc = '0; s_active = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        zero_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        req = 4'hF; req_tail = 4'hF; active = 1'b1;
        #1;
        total++; if (gnt !== 4'h0 || gnt_vld !== 1'b0) begin bad++; $display("FAIL reset_gnt: got %b/%b want 0000/0", gnt, gnt_vld); end
        total++; if (vc_empty !== 4'hF || vc_full !== 4'h0) begin bad++; $display("FAIL reset_flags: got empty=%b full=%b want 1111/0000", vc_empty, vc_full); end
        total++; if (errors !== 2'b00) begin bad++; $display("FAIL reset_errors: got %b want 00", errors); end
        total++; if (s_empty !== 3'b111 || s_full !== 3'b000) begin bad++; $display("FAIL reset_small_flags: got %b/%b want 111/000", s_empty, s_full); end
        do_reset();
    endtask

    task automatic test_rr_wrap();
        logic [3:0] want [5];
        want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0100; want[3] = 4'b1000; want[4] = 4'b0001;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(4'hF, 4'hF, 1'b0, 2'd0, 1'b1);
            total++; if (gnt !== want[i] || gnt !== exp_gnt) begin bad++; $display("FAIL rr_wrap[%0d]: got %b want %b", i, gnt, want[i]); end
            tick();
        end
    endtask

    task automatic test_vc_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(4'b0100, 4'b0100, 1'b0, 2'd0, 1'b1);
            total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL drain[%0d]: got %b want 0100", i, gnt); end
            tick();
        end
        drive(4'b0100, 4'b0100, 1'b0, 2'd0, 1'b1);
        total++; if (vc_full !== 4'b0100 || gnt !== 4'h0) begin bad++; $display("FAIL vc2_full: got full=%b gnt=%b want 0100/0000", vc_full, gnt); end
        tick();
        drive(4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1);
        total++; if (gnt !== (BYP ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL credit_cycle: got %b want %b", gnt, BYP ? 4'b0100 : 4'b0000); end
        tick();
        drive(4'b0100, 4'b0100, 1'b0, 2'd0, 1'b1);
        total++; if (gnt !== (BYP ? 4'b0000 : 4'b0100)) begin bad++; $display("FAIL credit_next: got %b want %b", gnt, BYP ? 4'b0000 : 4'b0100); end
        tick();
    endtask

    task automatic test_packet_lock();
        do_reset();
        drive(4'b0001, 4'b0001, 1'b0, 2'd0, 1'b1);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL lock_pre: got %b want 0001", gnt); end
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(4'b1011, (k == 2) ? 4'b0010 : 4'b0000, 1'b0, 2'd0, 1'b1);
            total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL lock_flit[%0d]: got %b want 0010", k, gnt); end
            tick();
        end
        drive(4'b1001, 4'b1001, 1'b0, 2'd0, 1'b1);
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL lock_after: got %b want 1000", gnt); end
        tick();
    endtask

    task automatic test_locked_starve();
        do_reset();
        drive(4'b0010, 4'b0000, 1'b0, 2'd0, 1'b1);
        tick();
        for (int k = 0; k < 7; k++) begin
            drive(4'b0011, 4'b0000, 1'b0, 2'd0, 1'b1);
            total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL starve_body[%0d]: got %b want 0010", k, gnt); end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(4'b0011, 4'b0000, 1'b0, 2'd0, 1'b1);
            total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL starve_idle[%0d]: got %b want 0000", k, gnt); end
            tick();
        end
        drive(4'b0011, 4'b0000, 1'b1, 2'd1, 1'b1);
        total++; if (gnt !== exp_gnt || gnt[0] !== 1'b0) begin bad++; $display("FAIL starve_cred: got %b want %b", gnt, exp_gnt); end
        tick();
        drive(4'b0011, 4'b0010, 1'b0, 2'd0, 1'b1);
        total++; if (gnt !== exp_gnt || gnt[0] !== 1'b0) begin bad++; $display("FAIL starve_resume: got %b want %b", gnt, exp_gnt); end
        tick();
    endtask

    task automatic test_credit_math();
        int cnt;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(4'b0001, 4'b0001, 1'b0, 2'd0, 1'b1);
            tick();
        end
        drive(4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1);
        total++; if (gnt !== 4'b0001 || errors !== 2'b00) begin bad++; $display("FAIL gnt_and_cred: got %b err=%b want 0001 err=00", gnt, errors); end
        tick();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            drive(4'b0001, 4'b0001, 1'b0, 2'd0, 1'b1);
            if (gnt[0]) cnt++;
            tick();
        end
        total++; if (cnt !== 5) begin bad++; $display("FAIL free_stays5: got %0d grants want 5", cnt); end
        drive(4'b0000, 4'b0000, 1'b1, 2'd3, 1'b1);
        total++; if (errors !== 2'b01) begin bad++; $display("FAIL overflow_err: got %b want 01", errors); end
        tick();
        drive(4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1);
        total++; if (vc_empty !== 4'b1110 || vc_full !== 4'b0001) begin bad++; $display("FAIL overflow_flags: got %b/%b want 1110/0001", vc_empty, vc_full); end
        tick();
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            drive(4'b1000, 4'b1000, 1'b0, 2'd0, 1'b1);
            if (gnt[3]) cnt++;
            tick();
        end
        total++; if (cnt !== 8) begin bad++; $display("FAIL saturate: got %0d grants want 8", cnt); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(4'b0100, 4'b0000, 1'b0, 2'd0, 1'b1);
            tick();
        end
        drive(4'hF, 4'h0, 1'b0, 2'd0, 1'b1);
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL midpkt_locked: got %b want 0100", gnt); end
        #1 reset = 1'b0;
        #1;
        total++; if (gnt !== 4'h0 || gnt_vld !== 1'b0) begin bad++; $display("FAIL midpkt_gnt: got %b want 0000", gnt); end
        total++; if (vc_empty !== 4'hF || vc_full !== 4'h0) begin bad++; $display("FAIL midpkt_flags: got %b/%b want 1111/0000", vc_empty, vc_full); end
        model_reset();
        @(negedge clk);
        reset = 1'b1; req = 4'hF; req_tail = 4'hF; cred_vld = 1'b0; active = 1'b1;
        #1;
        model_eval();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL midpkt_release: got %b want 0001", gnt); end
        tick();
    endtask

    task automatic test_depth1_small();
        do_reset();
        @(negedge clk); s_active = 1'b1; s_req = 3'b010; s_tail = 3'b010; #1;
        total++; if (s_gnt !== 3'b010) begin bad++; $display("FAIL d1_first: got %b want 010", s_gnt); end
        @(negedge clk); #1;
        total++; if (s_gnt !== 3'b000 || s_full !== 3'b010) begin bad++; $display("FAIL d1_full: got gnt=%b full=%b want 000/010", s_gnt, s_full); end
        @(negedge clk); s_cred_vld = 1'b1; s_cred_vc = 2'd3; #1;
        total++; if (s_errors !== 2'b10 || s_gnt !== 3'b000) begin bad++; $display("FAIL d1_illegal: got err=%b gnt=%b want 10/000", s_errors, s_gnt); end
        @(negedge clk); s_cred_vc = 2'd0; #1;
        total++; if (s_errors !== 2'b01 || s_full !== 3'b010) begin bad++; $display("FAIL d1_ovf: got err=%b full=%b want 01/010", s_errors, s_full); end
        @(negedge clk); s_cred_vc = 2'd1; #1;
        total++; if (s_gnt !== (BYP ? 3'b010 : 3'b000) || s_errors !== 2'b00) begin bad++; $display("FAIL d1_cred: got %b err=%b", s_gnt, s_errors); end
        @(negedge clk); s_cred_vld = 1'b0; #1;
        total++; if (s_gnt !== (BYP ? 3'b000 : 3'b010)) begin bad++; $display("FAIL d1_next: got %b want %b", s_gnt, BYP ? 3'b000 : 3'b010); end
        @(negedge clk); s_req = 3'b000; s_active = 1'b0;
    endtask

    task automatic test_random();
        logic act;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            act = ($urandom_range(0, 7) != 0);
            drive(4'($urandom), 4'($urandom), act && ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), act);
            total++; if (gnt !== exp_gnt || gnt_vld !== (|exp_gnt)) begin bad++; $display("FAIL rand_gnt[%0d]: got %b/%b want %b", n, gnt, gnt_vld, exp_gnt); end
            total++; if (errors !== exp_err) begin bad++; $display("FAIL rand_err[%0d]: got %b want %b", n, errors, exp_err); end
            total++; if (vc_empty !== exp_empty || vc_full !== exp_full) begin bad++; $display("FAIL rand_flags[%0d]: got %b/%b want %b/%b", n, vc_empty, vc_full, exp_empty, exp_full); end
            tick();
        end
    endtask

    initial begin
        reset = 1'b0;
        zero_inputs();
        model_reset();
        test_reset();
        test_rr_wrap();
        test_vc_full();
        test_packet_lock();
        test_locked_starve();
        test_credit_math();
        test_reset_mid_packet();
        test_depth1_small();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
